// File: rtl/branch_redirect_unit_if.sv
// Fetch-side redirect/stall bundle between the pipeline (master) and the branch redirect unit (slave).
// The master drives the EX/ID status; the slave returns the redirect, flush, stall and perf signals.
interface branch_redirect_unit_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
);
  logic              br_valid_EX;
  logic              br_uncond_EX;
  logic              br_cbz_EX;
  logic              br_cbnz_EX;
  logic              alu_zero_EX;
  logic [ADDR_W-1:0] pc_EX;
  logic [ADDR_W-1:0] br_offset_EX;
  logic              stall_req_ID;

  logic              PCSrc;
  logic [ADDR_W-1:0] TargetPC;
  logic              branch_taken_MEM;
  logic [ADDR_W-1:0] pc_MEM;
  logic              pc_stall;
  logic              flush;
  logic              stall_err;
  logic [CNT_W-1:0]  br_count;
  logic [CNT_W-1:0]  taken_count;

  modport master (
    output br_valid_EX, br_uncond_EX, br_cbz_EX, br_cbnz_EX, alu_zero_EX,
           pc_EX, br_offset_EX, stall_req_ID,
    input  PCSrc, TargetPC, branch_taken_MEM, pc_MEM, pc_stall, flush,
           stall_err, br_count, taken_count
  );

  modport slave (
    input  br_valid_EX, br_uncond_EX, br_cbz_EX, br_cbnz_EX, alu_zero_EX,
           pc_EX, br_offset_EX, stall_req_ID,
    output PCSrc, TargetPC, branch_taken_MEM, pc_MEM, pc_stall, flush,
           stall_err, br_count, taken_count
  );
endinterface

// File: rtl/branch_redirect_unit.sv
// Resolves B/CBZ/CBNZ in EX, redirects fetch from MEM, squashes the shadow slots,
// and gates load-use stalls with a sticky watchdog plus branch perf counters.
module branch_redirect_unit #(
  parameter int ADDR_W    = 64,
  parameter int SHADOW    = 2,
  parameter int MAX_STALL = 8,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_redirect_unit_if.slave bus
);

  localparam int SQ_W  = $clog2(SHADOW + 1);
  localparam int RUN_W = $clog2(MAX_STALL + 1);

  logic              takenMem;
  logic [ADDR_W-1:0] targetReg;
  logic [ADDR_W-1:0] pcMemReg;
  logic [SQ_W-1:0]   sqCnt;
  logic [RUN_W-1:0]  stallRun;
  logic              stallErr;
  logic [CNT_W-1:0]  brCount;
  logic [CNT_W-1:0]  takenCount;

  logic              live;
  logic              takenEx;
  logic [ADDR_W-1:0] targetEx;
  logic              pcStall;

  // A branch only counts when it is not sitting behind a redirect or in its shadow.
  always_comb begin
    live     = bus.br_valid_EX & (sqCnt == '0) & ~takenMem;
    takenEx  = live & (bus.br_uncond_EX
                     | (bus.br_cbz_EX  &  bus.alu_zero_EX)
                     | (bus.br_cbnz_EX & ~bus.alu_zero_EX));
    targetEx = bus.pc_EX + (bus.br_offset_EX << 2);
    pcStall  = bus.stall_req_ID & ~takenMem & (sqCnt != SQ_W'(SHADOW));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      takenMem   <= 1'b0;
      targetReg  <= '0;
      pcMemReg   <= '0;
      sqCnt      <= '0;
      stallRun   <= '0;
      stallErr   <= 1'b0;
      brCount    <= '0;
      takenCount <= '0;
    end else begin
      takenMem <= takenEx;
      if (takenEx) begin
        targetReg <= targetEx;
        pcMemReg  <= bus.pc_EX;
      end

      if (takenMem)
        sqCnt <= SQ_W'(SHADOW);
      else if (sqCnt != '0)
        sqCnt <= sqCnt - 1'b1;

      // stallRun parks at MAX_STALL-1 so it cannot wrap during a long hang.
      if (pcStall) begin
        if (stallRun == RUN_W'(MAX_STALL - 1))
          stallErr <= 1'b1;
        else
          stallRun <= stallRun + 1'b1;
      end else begin
        stallRun <= '0;
      end

      brCount    <= brCount + CNT_W'(live);
      takenCount <= takenCount + CNT_W'(takenEx);
    end
  end

  assign bus.PCSrc            = takenMem;
  assign bus.flush            = takenMem;
  assign bus.branch_taken_MEM = takenMem;
  assign bus.TargetPC         = targetReg;
  assign bus.pc_MEM           = pcMemReg;
  assign bus.pc_stall         = pcStall;
  assign bus.stall_err        = stallErr;
  assign bus.br_count         = brCount;
  assign bus.taken_count      = takenCount;

endmodule
